// File: rtl/piece_pixel_fetch.sv
// Five-stage pixel fetch: screen pixel -> board square -> piece code -> sprite ROM
// palette index, with de/hs/vs delayed to stay aligned with the index.
module piece_pixel_fetch #(
  parameter int X0     = 80,
  parameter int Y0     = 0,
  parameter int SQ     = 60,
  parameter int ROM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  output logic [5:0]        sq_addr,
  input  logic [3:0]        sq_piece,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic              pix_opaque,
  output logic              pix_board,
  output logic              pix_dark,
  output logic              de_o,
  output logic              hs_o,
  output logic              vs_o
);

  localparam int SW = $clog2(SQ);
  localparam logic [9:0]        X_LO      = 10'(X0);
  localparam logic [9:0]        Y_LO      = 10'(Y0);
  localparam logic [9:0]        SPAN      = 10'(8 * SQ);
  localparam logic [SW-1:0]     SUB_LAST  = SW'(SQ - 1);
  localparam logic [ROM_AW-1:0] SPRITE_SZ = ROM_AW'(SQ * SQ);
  localparam logic [ROM_AW-1:0] SQ_W      = ROM_AW'(SQ);

  // Offsets wrap to large values left of / above the board, so one compare per axis suffices.
  logic [9:0]    x_off_s, y_off_s;
  logic          region_s, line_start_s, in_board_s;
  logic [SW-1:0] sx_r, sy_r, sx_s, sy_s;
  logic [2:0]    file_r, rank_r, file_s, rank_s;

  assign x_off_s      = draw_x - X_LO;
  assign y_off_s      = draw_y - Y_LO;
  assign region_s     = (x_off_s < SPAN) && (y_off_s < SPAN);
  assign line_start_s = (draw_x == X_LO);
  assign in_board_s   = region_s && de;

  // Step counters: current pixel's sub/file and sub/rank derived from the previous board pixel.
  always_comb begin
    sx_s   = '0;
    file_s = '0;
    sy_s   = sy_r;
    rank_s = rank_r;
    if (line_start_s) begin
      sx_s   = '0;
      file_s = 3'd0;
    end else if (sx_r == SUB_LAST) begin
      sx_s   = '0;
      file_s = file_r + 3'd1;
    end else begin
      sx_s   = sx_r + SW'(1);
      file_s = file_r;
    end
    if (line_start_s && (draw_y == Y_LO)) begin
      sy_s   = '0;
      rank_s = 3'd0;
    end else if (line_start_s && (sy_r == SUB_LAST)) begin
      sy_s   = '0;
      rank_s = rank_r + 3'd1;
    end else if (line_start_s) begin
      sy_s   = sy_r + SW'(1);
      rank_s = rank_r;
    end else begin
      sy_s   = sy_r;
      rank_s = rank_r;
    end
  end

  // Counter state only advances on board pixels; vertical state only at the line's first one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_r   <= '0;
      file_r <= 3'd0;
      sy_r   <= '0;
      rank_r <= 3'd0;
    end else if (region_s) begin
      sx_r   <= sx_s;
      file_r <= file_s;
      if (line_start_s) begin
        sy_r   <= sy_s;
        rank_r <= rank_s;
      end
    end
  end

  logic [SW-1:0] s1_sx, s1_sy, s2_sx, s2_sy;
  logic          s1_in, s1_dark, s2_in, s2_dark;
  logic [3:0]    s2_piece;
  logic          s3_present, s3_in, s3_dark;
  logic [3:0]    s4_data;
  logic          s4_present, s4_in, s4_dark;
  logic [4:0]    de_pipe, hs_pipe, vs_pipe;

  // Stages 1 and 2: square address and coordinates, then capture the piece code.
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_addr  <= 6'd0;
      s1_sx    <= '0;
      s1_sy    <= '0;
      s1_in    <= 1'b0;
      s1_dark  <= 1'b0;
      s2_piece <= 4'd0;
      s2_sx    <= '0;
      s2_sy    <= '0;
      s2_in    <= 1'b0;
      s2_dark  <= 1'b0;
    end else begin
      sq_addr  <= in_board_s ? {rank_s, file_s} : 6'd0;
      s1_sx    <= sx_s;
      s1_sy    <= sy_s;
      s1_in    <= in_board_s;
      s1_dark  <= rank_s[0] ^ file_s[0];
      s2_piece <= sq_piece;
      s2_sx    <= s1_sx;
      s2_sy    <= s1_sy;
      s2_in    <= s1_in;
      s2_dark  <= s1_dark;
    end
  end

  logic                present_s;
  logic [3:0]          slot_s;
  logic [ROM_AW-1:0]   rom_addr_s;

  // Sprite address; empty, unused codes and off-board pixels read address 0 and carry no piece.
  always_comb begin
    slot_s    = s2_piece - 4'd1;
    present_s = s2_in && (s2_piece >= 4'd1) && (s2_piece <= 4'd12);
    if (present_s) begin
      rom_addr_s = ROM_AW'(slot_s) * SPRITE_SZ + ROM_AW'(s2_sy) * SQ_W + ROM_AW'(s2_sx);
    end else begin
      rom_addr_s = '0;
    end
  end

  // Stages 3-5: ROM address, ROM data capture, output formation; sync signals delayed alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr   <= '0;
      s3_present <= 1'b0;
      s3_in      <= 1'b0;
      s3_dark    <= 1'b0;
      s4_data    <= 4'd0;
      s4_present <= 1'b0;
      s4_in      <= 1'b0;
      s4_dark    <= 1'b0;
      pix_index  <= 4'd0;
      pix_opaque <= 1'b0;
      pix_board  <= 1'b0;
      pix_dark   <= 1'b0;
      de_pipe    <= 5'b00000;
      hs_pipe    <= 5'b11111;
      vs_pipe    <= 5'b11111;
    end else begin
      rom_addr   <= rom_addr_s;
      s3_present <= present_s;
      s3_in      <= s2_in;
      s3_dark    <= s2_dark;
      s4_data    <= rom_data;
      s4_present <= s3_present;
      s4_in      <= s3_in;
      s4_dark    <= s3_dark;
      pix_index  <= s4_present ? s4_data : 4'd0;
      pix_opaque <= s4_present && (s4_data != 4'd0);
      pix_board  <= s4_in;
      pix_dark   <= s4_dark && s4_in;
      de_pipe    <= {de_pipe[3:0], de};
      hs_pipe    <= {hs_pipe[3:0], hs};
      vs_pipe    <= {vs_pipe[3:0], vs};
    end
  end

  assign de_o = de_pipe[4];
  assign hs_o = hs_pipe[4];
  assign vs_o = vs_pipe[4];

endmodule
